// File: rtl/sdram_responder.sv
// sdram_responder: single-chip SDRAM device model with protocol checking and CAS-latency read pipeline
module sdram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        sdram_cs_n,
    input  logic        sdram_ras_n,
    input  logic        sdram_cas_n,
    input  logic        sdram_we_n,
    input  logic        sdram_cke,
    input  logic [1:0]  sdram_ba,
    input  logic [12:0] sdram_addr,
    input  logic [1:0]  sdram_dqm,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic [1:0]  sdram_dq_oe,
    output logic        cmd_err,
    output logic [2:0]  err_code,
    output logic [15:0] refresh_cnt
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;
    localparam logic ST_UNINIT = 1'b0;
    localparam logic ST_READY  = 1'b1;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    logic                r_state;
    logic                r_cl3;
    logic [3:0]          r_act;
    logic [ROW_BITS-1:0] r_row [4];
    logic [2:0]          r_pv;
    logic [15:0]         r_pd [3];
    logic [1:0]          r_po [3];
    logic [15:0]         r_mem [0:(1<<AW)-1];

    logic [3:0]    w_cmd;
    logic          w_act, w_rd, w_wr, w_pre, w_ref, w_lmr;
    logic          w_uninit, w_bank_open, w_all_idle, w_cl_ok;
    logic          w_act_ok, w_rd_ok, w_wr_ok, w_lmr_ok, w_collide, w_ap;
    logic [2:0]    w_cl_new;
    logic [2:0]    w_err;
    logic [AW-1:0] w_maddr;
    logic [15:0]   w_rdata;
    logic          w_unused;

    assign w_cmd       = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign w_act       = sdram_cke && (w_cmd == CMD_ACT);
    assign w_rd        = sdram_cke && (w_cmd == CMD_RD);
    assign w_wr        = sdram_cke && (w_cmd == CMD_WR);
    assign w_pre       = sdram_cke && (w_cmd == CMD_PRE);
    assign w_ref       = sdram_cke && (w_cmd == CMD_REF);
    assign w_lmr       = sdram_cke && (w_cmd == CMD_LMR);
    assign w_uninit    = (r_state == ST_UNINIT);
    assign w_bank_open = r_act[sdram_ba];
    assign w_all_idle  = (r_act == 4'd0);
    assign w_cl_new    = sdram_addr[6:4];
    assign w_cl_ok     = (w_cl_new == 3'd2) || (w_cl_new == 3'd3);
    assign w_ap        = sdram_addr[10];
    assign w_act_ok    = w_act && !w_uninit && !w_bank_open;
    assign w_rd_ok     = w_rd && !w_uninit && w_bank_open;
    assign w_wr_ok     = w_wr && !w_uninit && w_bank_open;
    assign w_lmr_ok    = w_lmr && w_cl_ok && w_all_idle;
    assign w_collide   = w_wr_ok && r_pv[0];
    assign w_maddr     = {sdram_ba, r_row[sdram_ba], sdram_addr[COL_BITS-1:0]};
    assign w_rdata     = r_mem[w_maddr];
    assign w_unused    = ^sdram_addr;

    // First matching condition wins, lowest code first
    always_comb begin
        w_err = ((w_act || w_rd || w_wr) && w_uninit) ? 3'd1 :
                (w_lmr && !w_cl_ok)                   ? 3'd2 :
                (w_lmr && !w_all_idle)                ? 3'd3 :
                (w_act && w_bank_open)                ? 3'd4 :
                ((w_rd || w_wr) && !w_bank_open)      ? 3'd5 :
                w_collide                             ? 3'd6 :
                (w_ref && !w_all_idle)                ? 3'd7 : 3'd0;
    end

    // Storage array is never reset so contents survive reset_reset
    always_ff @(posedge clk_clk) begin
        if (w_wr_ok && !sdram_dqm[0]) r_mem[w_maddr][7:0] <= sdram_dq_in[7:0];
        if (w_wr_ok && !sdram_dqm[1]) r_mem[w_maddr][15:8] <= sdram_dq_in[15:8];
    end

    // Command state, bank tracking, error latch, refresh count and read pipeline
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state      <= ST_UNINIT;
            r_cl3        <= 1'b0;
            r_act        <= 4'd0;
            r_row        <= '{default: '0};
            r_pv         <= 3'd0;
            r_pd         <= '{default: '0};
            r_po         <= '{default: '0};
            sdram_dq_out <= 16'd0;
            sdram_dq_oe  <= 2'd0;
            cmd_err      <= 1'b0;
            err_code     <= 3'd0;
            refresh_cnt  <= 16'd0;
        end else if (sdram_cke) begin
            if (w_err != 3'd0 && !cmd_err) begin
                cmd_err  <= 1'b1;
                err_code <= w_err;
            end
            if (w_lmr_ok) begin
                r_state <= ST_READY;
                r_cl3   <= (w_cl_new == 3'd3);
            end
            if (w_act_ok) begin
                r_act[sdram_ba] <= 1'b1;
                r_row[sdram_ba] <= sdram_addr[ROW_BITS-1:0];
            end
            if ((w_rd_ok || w_wr_ok) && w_ap) r_act[sdram_ba] <= 1'b0;
            if (w_pre && w_ap) r_act <= 4'd0;
            if (w_pre && !w_ap) r_act[sdram_ba] <= 1'b0;
            if (w_ref && w_all_idle) refresh_cnt <= refresh_cnt + 16'd1;
            r_pv         <= {w_rd_ok && r_cl3, r_pv[2] || (w_rd_ok && !r_cl3), r_pv[1]};
            r_pd[2]      <= w_rdata;
            r_po[2]      <= ~sdram_dqm;
            r_pd[1]      <= (w_rd_ok && !r_cl3) ? w_rdata : r_pd[2];
            r_po[1]      <= (w_rd_ok && !r_cl3) ? ~sdram_dqm : r_po[2];
            r_pd[0]      <= r_pd[1];
            r_po[0]      <= r_po[1];
            sdram_dq_out <= r_pv[0] ? r_pd[0] : 16'd0;
            sdram_dq_oe  <= r_pv[0] ? r_po[0] : 2'd0;
        end
    end
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: directed and randomized checks of sdram_responder against a cycle-scheduled reference model
module tb_sdram_responder;
    localparam int RB = 4;
    localparam int CB = 4;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs_n, ras_n, cas_n, we_n, cke;
    logic [1:0]  ba, dqm, dq_oe;
    logic [12:0] addr;
    logic [15:0] dq_in, dq_out, refresh_cnt;
    logic        cmd_err;
    logic [2:0]  err_code;

    int checks = 0;
    int failures = 0;

    bit          m_init, m_err;
    int          m_cl, m_code, m_ref, cyc;
    bit          m_act [4];
    int          m_row [4];
    logic [15:0] m_mem [int];
    logic [1:0]  m_km [int];
    logic [15:0] e_d [int];
    logic [1:0]  e_o [int];
    bit          e_k [int];

    sdram_responder #(.ROW_BITS(RB), .COL_BITS(CB)) dut (
        .clk_clk(clk), .reset_reset(rst),
        .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_cke(cke), .sdram_ba(ba), .sdram_addr(addr), .sdram_dqm(dqm),
        .sdram_dq_in(dq_in), .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe),
        .cmd_err(cmd_err), .err_code(err_code), .refresh_cnt(refresh_cnt)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        m_init = 0; m_err = 0; m_cl = 2; m_code = 0; m_ref = 0;
        for (int i = 0; i < 4; i++) m_act[i] = 0;
        e_d.delete(); e_o.delete(); e_k.delete();
    endtask

    // Reference: each accepted READ schedules its word at cycle number (command cycle + CL)
    task automatic mdl(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic [1:0] m, input logic [15:0] d);
        int e, idx, due;
        bit any;
        logic [15:0] w;
        logic [1:0] kk;
        e = 0;
        cyc++;
        any = m_act[0] | m_act[1] | m_act[2] | m_act[3];
        idx = (int'(b) << (RB + CB)) + (m_row[b] << CB) + int'(a[CB-1:0]);
        case (c)
            ACT: if (!m_init) e = 1; else if (m_act[b]) e = 4; else begin m_act[b] = 1; m_row[b] = int'(a[RB-1:0]); end
            RD, WR: begin
                if (!m_init) e = 1;
                else if (!m_act[b]) e = 5;
                else begin
                    if (c == WR) begin
                        if (e_o.exists(cyc)) e = 6;
                        if (!m_mem.exists(idx)) begin m_mem[idx] = 16'h0; m_km[idx] = 2'b00; end
                        w = m_mem[idx]; kk = m_km[idx];
                        if (!m[0]) begin w[7:0] = d[7:0]; kk[0] = 1'b1; end
                        if (!m[1]) begin w[15:8] = d[15:8]; kk[1] = 1'b1; end
                        m_mem[idx] = w; m_km[idx] = kk;
                    end else begin
                        due = cyc + m_cl;
                        e_o[due] = ~m;
                        e_k[due] = m_mem.exists(idx) && (m_km[idx] == 2'b11);
                        e_d[due] = m_mem.exists(idx) ? m_mem[idx] : 16'h0;
                    end
                    if (a[10]) m_act[b] = 0;
                end
            end
            LMR: if (a[6:4] != 3'd2 && a[6:4] != 3'd3) e = 2; else if (any) e = 3; else begin m_cl = int'(a[6:4]); m_init = 1; end
            PRE: if (a[10]) for (int i = 0; i < 4; i++) m_act[i] = 0; else m_act[b] = 0;
            REF: if (any) e = 7; else m_ref = (m_ref + 1) & 16'hFFFF;
            default: ;
        endcase
        if (e != 0 && !m_err) begin m_err = 1; m_code = e; end
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b = 2'd0, input logic [12:0] a = 13'd0,
                        input logic [1:0] m = 2'b00, input logic [15:0] d = 16'h0, input logic k = 1'b1);
        {cs_n, ras_n, cas_n, we_n} = c; ba = b; addr = a; dqm = m; dq_in = d; cke = k;
        @(posedge clk);
        if (k) mdl(c, b, a, m, d);
        @(negedge clk);
        {cs_n, ras_n, cas_n, we_n} = NOP; cke = 1'b1;
    endtask

    task automatic do_reset();
        {cs_n, ras_n, cas_n, we_n} = NOP;
        rst = 1'b1;
        m_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (dq_oe !== 2'b00) begin failures++; $display("FAIL reset_oe got=%b exp=00", dq_oe); end
        if (dq_out !== 16'h0) begin failures++; $display("FAIL reset_dq got=%h exp=0000", dq_out); end
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cmd_err); end
        if (err_code !== 3'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", err_code); end
        if (refresh_cnt !== 16'd0) begin failures++; $display("FAIL reset_refcnt got=%0d exp=0", refresh_cnt); end
    endtask

    task automatic test_basic_rw();
        step(LMR, 0, 13'h020);
        step(ACT, 1, 13'h003);
        step(WR, 1, 13'h005, 2'b00, 16'hBEEF);
        step(RD, 1, 13'h005, 2'b00);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(NOP);
            checks++;
            if (dq_oe !== ((i == 2) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL basic_oe i=%0d got=%b exp=%b", i, dq_oe, (i == 2) ? 2'b11 : 2'b00); end
            if (i == 2) begin
                checks++;
                if (dq_out !== 16'hBEEF) begin failures++; $display("FAIL basic_dq got=%h exp=beef", dq_out); end
            end
        end
        checks++;
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", cmd_err); end
    endtask

    task automatic test_cl3_mask();
        step(PRE, 0, 13'h400);
        step(LMR, 0, 13'h030);
        step(ACT, 2, 13'h007);
        step(WR, 2, 13'h009, 2'b00, 16'h1234);
        step(WR, 2, 13'h009, 2'b01, 16'hABCD);
        step(RD, 2, 13'h009, 2'b10);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(NOP);
            checks++;
            if (dq_oe !== ((i == 3) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL cl3_oe i=%0d got=%b exp=%b", i, dq_oe, (i == 3) ? 2'b01 : 2'b00); end
            if (i == 3) begin
                checks++;
                if (dq_out !== 16'hAB34) begin failures++; $display("FAIL cl3_dq got=%h exp=ab34", dq_out); end
            end
        end
        checks++;
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL cl3_err got=%b exp=0", cmd_err); end
    endtask

    task automatic test_uninit_err();
        do_reset();
        step(ACT, 0, 13'h001);
        checks += 2;
        if (cmd_err !== 1'b1) begin failures++; $display("FAIL uninit_err got=%b exp=1", cmd_err); end
        if (err_code !== 3'd1) begin failures++; $display("FAIL uninit_code got=%0d exp=1", err_code); end
        step(RD, 0, 13'h000);
        step(NOP);
        step(NOP);
        checks += 2;
        if (err_code !== 3'd1) begin failures++; $display("FAIL uninit_code2 got=%0d exp=1", err_code); end
        if (dq_oe !== 2'b00) begin failures++; $display("FAIL uninit_oe got=%b exp=00", dq_oe); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(LMR, 0, 13'h020);
        step(ACT, 0, 13'h001);
        for (int c = 0; c < 4; c++) step(WR, 0, 13'(c), 2'b00, 16'hC000 | 16'(c));
        for (int j = 0; j < 8; j++) begin
            if (j < 4) step(RD, 0, 13'(j)); else step(NOP);
            checks++;
            if (dq_oe !== ((j >= 2 && j <= 5) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL b2b_oe j=%0d got=%b", j, dq_oe); end
            if (j >= 2 && j <= 5) begin
                checks++;
                if (dq_out !== (16'hC000 | 16'(j - 2))) begin failures++; $display("FAIL b2b_dq j=%0d got=%h exp=%h", j, dq_out, 16'hC000 | 16'(j - 2)); end
            end
        end
        checks++;
        if (cmd_err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", cmd_err); end
    endtask

    task automatic test_refresh();
        do_reset();
        step(LMR, 0, 13'h020);
        step(ACT, 0, 13'h000);
        step(REF);
        checks += 2;
        if (err_code !== 3'd7) begin failures++; $display("FAIL ref_code got=%0d exp=7", err_code); end
        if (refresh_cnt !== 16'd0) begin failures++; $display("FAIL ref_cnt0 got=%0d exp=0", refresh_cnt); end
        step(PRE, 0, 13'h400);
        step(REF);
        checks++;
        if (refresh_cnt !== 16'd1) begin failures++; $display("FAIL ref_cnt1 got=%0d exp=1", refresh_cnt); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        step(LMR, 0, 13'h020);
        step(ACT, 1, 13'h003);
        step(RD, 1, 13'h005);
        rst = 1'b1;
        m_reset();
        #1;
        checks += 3;
        if (dq_oe !== 2'b00 || dq_out !== 16'h0) begin failures++; $display("FAIL midrd_dq oe=%b dq=%h exp=00/0000", dq_oe, dq_out); end
        if (cmd_err !== 1'b0 || err_code !== 3'd0) begin failures++; $display("FAIL midrd_err got=%b/%0d exp=0/0", cmd_err, err_code); end
        if (refresh_cnt !== 16'd0) begin failures++; $display("FAIL midrd_cnt got=%0d exp=0", refresh_cnt); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(NOP);
            checks++;
            if (dq_oe !== 2'b00) begin failures++; $display("FAIL midrd_oe i=%0d got=%b exp=00", i, dq_oe); end
        end
        step(LMR, 0, 13'h020);
        step(ACT, 1, 13'h003);
        step(RD, 1, 13'h005);
        step(NOP);
        step(NOP);
        checks++;
        if (dq_out !== 16'hBEEF || dq_oe !== 2'b11) begin failures++; $display("FAIL keep_mem got=%h/%b exp=beef/11", dq_out, dq_oe); end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [12:0] a;
        int r;
        logic [1:0] eo;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            else begin
                r = $urandom_range(0, 99);
                a = 13'd0;
                a[10] = ($urandom_range(0, 3) == 0);
                c = (r < 8) ? LMR : (r < 23) ? ACT : (r < 48) ? RD : (r < 68) ? WR :
                    (r < 78) ? PRE : (r < 83) ? REF : (r < 90) ? {1'b1, 3'($urandom)} : NOP;
                if (c == ACT) a[RB-1:0] = RB'($urandom_range(0, 1));
                if (c == RD || c == WR) a[CB-1:0] = CB'($urandom_range(0, 3));
                if (c == LMR) a[6:4] = 3'($urandom_range(1, 4));
                step(c, 2'($urandom), a, 2'($urandom), 16'($urandom), $urandom_range(0, 19) != 0);
            end
            eo = e_o.exists(cyc) ? e_o[cyc] : 2'b00;
            checks += 4;
            if (dq_oe !== eo) begin failures++; $display("FAIL rnd_oe cyc=%0d got=%b exp=%b", cyc, dq_oe, eo); end
            if (cmd_err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, cmd_err, m_err); end
            if (err_code !== 3'(m_code)) begin failures++; $display("FAIL rnd_code cyc=%0d got=%0d exp=%0d", cyc, err_code, m_code); end
            if (refresh_cnt !== 16'(m_ref)) begin failures++; $display("FAIL rnd_ref cyc=%0d got=%0d exp=%0d", cyc, refresh_cnt, m_ref); end
            if (e_o.exists(cyc) && e_k[cyc]) begin
                checks++;
                if (dq_out !== e_d[cyc]) begin failures++; $display("FAIL rnd_dq cyc=%0d got=%h exp=%h", cyc, dq_out, e_d[cyc]); end
            end
        end
    endtask

    initial begin
        {cs_n, ras_n, cas_n, we_n} = NOP;
        cke = 1'b1; ba = 2'd0; addr = 13'd0; dqm = 2'b00; dq_in = 16'h0;
        cyc = 0;
        for (int i = 0; i < 4; i++) m_row[i] = 0;
        @(negedge clk);
        test_reset();
        test_basic_rw();
        test_cl3_mask();
        test_uninit_err();
        test_back_to_back();
        test_refresh();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
